// File: rtl/cache_dm_wb_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache.
// Holds the 2-bit controller state encoding and the log2 helper used to size address fields.
package cache_dm_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_REFILL    = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Data array for cache_dm_wb: one word written per clock, combinational read.
// Addressed as {set index, word offset}.
module cache_line_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage arrays have no reset; the controller's valid bits decide whether contents mean anything.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with burst refill/writeback,
// bulk invalidate and saturating hit/miss statistics.
module cache_dm_wb
    import cache_dm_wb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              inv,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int OFF_W  = clog2(LINE_WORDS);
    localparam int IDX_W  = clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int RAM_AW = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [OFF_W-1:0]  beat;
    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;
    logic [TAG_W-1:0]  tags [SETS];

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic              last_ack;

    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [RAM_AW-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign req_off  = req_addr[OFF_W-1:0];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign hit      = valid[req_idx] && (tags[req_idx] == req_tag);
    assign last_ack = mem_ack && (beat == LAST_BEAT);

    cache_line_ram #(
        .DATA_W (DATA_W),
        .AW     (RAM_AW),
        .DEPTH  (SETS * LINE_WORDS)
    ) u_data (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ram_we    = 1'b0;
        ram_waddr = {req_idx, req_off};
        ram_wdata = req_wdata;
        ram_raddr = {req_idx, req_off};

        unique case (state)
            ST_IDLE: begin
                if (!inv && cpu_req) state_nxt = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = ram_rdata;
                    ram_we    = req_we;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = (valid[req_idx] && dirty[req_idx]) ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tags[req_idx], req_idx, beat};
                ram_raddr = {req_idx, beat};
                mem_wdata = ram_rdata;
                if (last_ack) state_nxt = ST_REFILL;
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, beat};
                if (mem_ack) begin
                    ram_we    = 1'b1;
                    ram_waddr = {req_idx, beat};
                    ram_wdata = mem_rdata;
                end
                if (last_ack) state_nxt = ST_COMPARE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            beat      <= '0;
            valid     <= '0;
            dirty     <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (inv) begin
                        valid <= '0;
                        dirty <= '0;
                    end else if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                    end
                end
                ST_COMPARE: begin
                    if (hit) begin
                        if (req_we) dirty[req_idx] <= 1'b1;
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                    end else if (miss_cnt != '1) begin
                        miss_cnt <= miss_cnt + CNT_W'(1);
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack) beat <= beat + OFF_W'(1);
                    if (last_ack) dirty[req_idx] <= 1'b0;
                end
                ST_REFILL: begin
                    if (mem_ack) beat <= beat + OFF_W'(1);
                    if (last_ack) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The tag of a set is only meaningful once its valid bit is set after a refill.
    always_ff @(posedge clk) begin
        if (state == ST_REFILL && last_ack) tags[req_idx] <= req_tag;
    end

endmodule

// File: tb/tb_cache_dm_wb.sv
// Self-checking bench for cache_dm_wb: directed walk-through plus randomized traffic,
// checked by a scoreboard against a line-level model of cache contents and memory.
`timescale 1ns/1ps
module tb_cache_dm_wb;

    localparam int LINE_WORDS = 4;
    localparam int SETS       = 16;
    localparam int LAT        = 2;
    localparam longint CNT_MAX = 65535;
    localparam longint SAT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        inv = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic [31:0] cpu_rdata, mem_wdata;
    logic        cpu_ready, mem_req, mem_we;
    logic [15:0] mem_addr, hit_cnt, miss_cnt;

    logic [31:0] s_cpu_rdata, s_mem_wdata;
    logic        s_cpu_ready, s_mem_req, s_mem_we;
    logic [15:0] s_mem_addr;
    logic [3:0]  s_hit_cnt, s_miss_cnt;

    cache_dm_wb dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .inv(inv),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Narrow-counter copy sharing all inputs; its bursts match the main instance exactly.
    cache_dm_wb #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(s_cpu_rdata), .cpu_ready(s_cpu_ready), .inv(inv),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    typedef struct { bit we; logic [15:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct { bit we; logic [15:0] addr; logic [31:0] rdata; int lat; int acc; } rsp_t;

    beat_t exp_beats[$];
    rsp_t  exp_rsp[$];

    logic [31:0] main_mem [int];
    logic [31:0] view_mem [int];
    int          line_base [SETS];
    bit          line_mod  [SETS];
    longint      exp_hits = 0;
    longint      exp_misses = 0;
    bit          noise_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    endtask

    function automatic logic [31:0] main_rd(input int a);
        if (main_mem.exists(a)) return main_mem[a];
        return 32'(a) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] view_rd(input int a);
        if (view_mem.exists(a)) return view_mem[a];
        return main_rd(a);
    endfunction

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    // Lines dropped without writeback lose their stores: the CPU view falls back to memory.
    task automatic model_drop_lines();
        for (int s = 0; s < SETS; s++) begin
            if (line_base[s] >= 0 && line_mod[s])
                for (int k = 0; k < LINE_WORDS; k++) view_mem.delete(line_base[s] + k);
            line_base[s] = -1;
            line_mod[s]  = 1'b0;
        end
    endtask

    task automatic check_counters();
        check("hit_cnt", hit_cnt, sat(exp_hits, CNT_MAX));
        check("miss_cnt", miss_cnt, sat(exp_misses, CNT_MAX));
        check("sat_hit_cnt", s_hit_cnt, sat(exp_hits, SAT_MAX));
        check("sat_miss_cnt", s_miss_cnt, sat(exp_misses, SAT_MAX));
    endtask

    // Called at posedge+1 of a cycle where the cache is idle.
    task automatic issue(input bit we, input logic [15:0] addr, input logic [31:0] wd, input bit with_inv);
        int s, base, old;
        bit miss, wb;
        rsp_t r;
        if (with_inv) model_drop_lines();
        s    = (int'(addr) / LINE_WORDS) % SETS;
        base = int'(addr) - (int'(addr) % LINE_WORDS);
        old  = line_base[s];
        miss = (old != base);
        wb   = miss && (old >= 0) && line_mod[s];
        if (wb)
            for (int k = 0; k < LINE_WORDS; k++) exp_beats.push_back('{1'b1, 16'(old + k), view_rd(old + k)});
        if (miss) begin
            for (int k = 0; k < LINE_WORDS; k++) exp_beats.push_back('{1'b0, 16'(base + k), 32'h0});
            line_base[s] = base;
            line_mod[s]  = 1'b0;
            exp_misses++;
        end
        exp_hits++;
        r.we    = we;
        r.addr  = addr;
        r.rdata = view_rd(int'(addr));
        r.lat   = miss ? (2 + LINE_WORDS * LAT * (wb ? 2 : 1)) : 1;
        if (we) begin
            view_mem[int'(addr)] = wd;
            line_mod[s] = 1'b1;
        end
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        inv       = with_inv;
        if (with_inv) begin
            @(posedge clk); #1;
            inv = 1'b0;
        end
        r.acc = cyc;
        exp_rsp.push_back(r);
    endtask

    task automatic complete();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1'b1;
                break;
            end
            if (noise_on && i > 0) inv = ($urandom_range(0, 3) == 0);
        end
        cpu_req = 1'b0;
        inv     = 1'b0;
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL cpu_ready_timeout actual=no_ready expected=ready addr=%0h", cpu_addr);
            finish_run();
        end
        @(posedge clk); #1;
        check_counters();
    endtask

    task automatic access(input bit we, input logic [15:0] addr, input logic [31:0] wd);
        issue(we, addr, wd, 1'b0);
        complete();
    endtask

    task automatic pulse_inv();
        inv = 1'b1;
        model_drop_lines();
        @(posedge clk); #1;
        inv = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        inv     = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        exp_beats.delete();
        exp_rsp.delete();
        model_drop_lines();
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Memory model: each beat is acknowledged after LAT cycles of mem_req; stray acks when idle.
    int    wait_cnt = 0;
    beat_t mb;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (mem_req) begin
                wait_cnt++;
                if (wait_cnt >= LAT) begin
                    mem_ack = 1'b1;
                    if (exp_beats.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_beat actual=addr_%0h_we_%0b expected=no_beat", mem_addr, mem_we);
                    end else begin
                        mb = exp_beats.pop_front();
                        check("beat_we", mem_we, mb.we);
                        check($sformatf("beat_addr_%0h", mb.addr), mem_addr, mb.addr);
                        if (mb.we) check($sformatf("beat_wdata_%0h", mb.addr), mem_wdata, mb.wdata);
                    end
                    if (mem_we) main_mem[int'(mem_addr)] = mem_wdata;
                    else        mem_rdata = main_rd(int'(mem_addr));
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    // Response monitor: pops the oldest expected completion whenever cpu_ready pulses.
    rsp_t mr;
    always @(negedge clk) begin
        if (rst_n && cpu_ready) begin
            if (exp_rsp.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ready actual=ready expected=idle addr=%0h", cpu_addr);
            end else begin
                mr = exp_rsp.pop_front();
                check($sformatf("latency_%0h", mr.addr), 64'(cyc - mr.acc), 64'(mr.lat));
                if (!mr.we) check($sformatf("rdata_%0h", mr.addr), cpu_rdata, mr.rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        checks++;
        fails++;
        $display("FAIL global_timeout actual=running expected=done");
        finish_run();
    end

    initial begin
        bit   found;
        logic [15:0] a;
        for (int s = 0; s < SETS; s++) begin
            line_base[s] = -1;
            line_mod[s]  = 1'b0;
        end
        #2;
        apply_reset();

        access(1'b0, 16'h0012, 32'h0);
        access(1'b0, 16'h0013, 32'h0);
        access(1'b1, 16'h0011, 32'hDEAD_BEEF);
        access(1'b0, 16'h0411, 32'h0);
        pulse_inv();
        access(1'b0, 16'h0411, 32'h0);

        issue(1'b0, 16'h0011, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (mem_req && !mem_we && exp_beats.size() == 2) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL refill_beat2_timeout actual=not_seen expected=beat2");
            finish_run();
        end
        apply_reset();
        access(1'b0, 16'h0411, 32'h0);

        for (int i = 0; i < 20; i++) access(1'b0, 16'h0411, 32'h0);

        access(1'b1, 16'h0822, 32'h1234_5678);
        access(1'b0, 16'h0822, 32'h0);

        noise_on = 1'b1;
        for (int n = 0; n < 400; n++) begin
            a = 16'($urandom_range(0, 3) * 64 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            issue($urandom_range(0, 9) < 4, a, $urandom, $urandom_range(0, 29) == 0);
            complete();
        end

        check("rsp_queue_drained", exp_rsp.size(), 0);
        check("beat_queue_drained", exp_beats.size(), 0);
        finish_run();
    end

endmodule
